// File: rtl/rename_history_ctrl_if.sv
// Rename/commit/flush handshake and recovery outputs of the rename history controller.
// The controller side uses the slave modport; the rename/ROB side uses master.
interface rename_history_ctrl_if #(
    parameter int AREG_W = 3,
    parameter int PREG_W = 5,
    parameter int CNT_W  = 5
);
    logic              ren_valid;
    logic [AREG_W-1:0] ren_arch;
    logic [PREG_W-1:0] ren_new_preg;
    logic [PREG_W-1:0] ren_old_preg;
    logic              ren_ready;
    logic              commit_valid;
    logic              flush;
    logic              rat_wr_en;
    logic [AREG_W-1:0] rat_wr_arch;
    logic [PREG_W-1:0] rat_wr_preg;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              err;

    modport master (
        output ren_valid, ren_arch, ren_new_preg, ren_old_preg, commit_valid, flush,
        input  ren_ready, rat_wr_en, rat_wr_arch, rat_wr_preg, free_valid, free_preg,
               busy, count, err
    );

    modport slave (
        input  ren_valid, ren_arch, ren_new_preg, ren_old_preg, commit_valid, flush,
        output ren_ready, rat_wr_en, rat_wr_arch, rat_wr_preg, free_valid, free_preg,
               busy, count, err
    );
endinterface

// File: rtl/rename_history_ctrl.sv
// Rename history buffer: frees old pregs on commit and, on flush, walks entries
// youngest-first restoring RAT mappings and returning squashed pregs.
module rename_history_ctrl #(
    parameter int DEPTH  = 16,
    parameter int AREG_W = 3,
    parameter int PREG_W = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    rename_history_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    logic [AREG_W-1:0] arch_mem_r [DEPTH];
    logic [PREG_W-1:0] new_mem_r  [DEPTH];
    logic [PREG_W-1:0] old_mem_r  [DEPTH];

    logic [0:0]        state_r, state_n;
    logic [PTR_W-1:0]  head_r, head_n;
    logic [PTR_W-1:0]  tail_r, tail_n;
    logic [CNT_W-1:0]  count_r, count_n;
    logic              err_r, err_n;
    logic              rat_wr_en_r, rat_wr_en_n;
    logic [AREG_W-1:0] rat_wr_arch_r, rat_wr_arch_n;
    logic [PREG_W-1:0] rat_wr_preg_r, rat_wr_preg_n;
    logic              free_valid_r, free_valid_n;
    logic [PREG_W-1:0] free_preg_r, free_preg_n;

    logic              ready_s;
    logic              commit_s;
    logic              push_s;
    logic [CNT_W-1:0]  count_post_commit_s;
    logic [PTR_W-1:0]  walk_idx_s;

    assign ready_s    = (state_r == ST_IDLE) && (count_r < CNT_W'(DEPTH));
    assign walk_idx_s = tail_r - PTR_W'(1);

    // Next-state: commit is applied before flush so the retiring instruction survives.
    always_comb begin
        state_n             = state_r;
        head_n              = head_r;
        tail_n              = tail_r;
        count_n             = count_r;
        err_n               = err_r;
        rat_wr_en_n         = 1'b0;
        rat_wr_arch_n       = {AREG_W{1'b0}};
        rat_wr_preg_n       = {PREG_W{1'b0}};
        free_valid_n        = 1'b0;
        free_preg_n         = {PREG_W{1'b0}};
        commit_s            = 1'b0;
        push_s              = 1'b0;
        count_post_commit_s = count_r;
        case (state_r)
            ST_IDLE: begin
                commit_s = bus.commit_valid && (count_r != {CNT_W{1'b0}});
                push_s   = bus.ren_valid && ready_s && !bus.flush;
                if (commit_s) begin
                    head_n              = head_r + PTR_W'(1);
                    free_valid_n        = 1'b1;
                    free_preg_n         = old_mem_r[head_r];
                    count_post_commit_s = count_r - CNT_W'(1);
                end else begin
                    count_post_commit_s = count_r;
                end
                if (bus.commit_valid && (count_r == {CNT_W{1'b0}})) begin
                    err_n = 1'b1;
                end else begin
                    err_n = err_r;
                end
                if (push_s) begin
                    tail_n  = tail_r + PTR_W'(1);
                    count_n = count_post_commit_s + CNT_W'(1);
                end else begin
                    count_n = count_post_commit_s;
                end
                if (bus.flush && (count_post_commit_s != {CNT_W{1'b0}})) begin
                    state_n = ST_WALK;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WALK: begin
                tail_n        = walk_idx_s;
                count_n       = count_r - CNT_W'(1);
                rat_wr_en_n   = 1'b1;
                rat_wr_arch_n = arch_mem_r[walk_idx_s];
                rat_wr_preg_n = old_mem_r[walk_idx_s];
                free_valid_n  = 1'b1;
                free_preg_n   = new_mem_r[walk_idx_s];
                if (count_r == CNT_W'(1)) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WALK;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control state and registered recovery/free outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            err_r         <= 1'b0;
            rat_wr_en_r   <= 1'b0;
            rat_wr_arch_r <= {AREG_W{1'b0}};
            rat_wr_preg_r <= {PREG_W{1'b0}};
            free_valid_r  <= 1'b0;
            free_preg_r   <= {PREG_W{1'b0}};
        end else begin
            state_r       <= state_n;
            head_r        <= head_n;
            tail_r        <= tail_n;
            count_r       <= count_n;
            err_r         <= err_n;
            rat_wr_en_r   <= rat_wr_en_n;
            rat_wr_arch_r <= rat_wr_arch_n;
            rat_wr_preg_r <= rat_wr_preg_n;
            free_valid_r  <= free_valid_n;
            free_preg_r   <= free_preg_n;
        end
    end

    // History storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            arch_mem_r[tail_r] <= bus.ren_arch;
            new_mem_r[tail_r]  <= bus.ren_new_preg;
            old_mem_r[tail_r]  <= bus.ren_old_preg;
        end
    end

    assign bus.ren_ready   = ready_s;
    assign bus.busy        = (state_r == ST_WALK);
    assign bus.count       = count_r;
    assign bus.err         = err_r;
    assign bus.rat_wr_en   = rat_wr_en_r;
    assign bus.rat_wr_arch = rat_wr_arch_r;
    assign bus.rat_wr_preg = rat_wr_preg_r;
    assign bus.free_valid  = free_valid_r;
    assign bus.free_preg   = free_preg_r;
endmodule

// File: tb/tb_rename_history_ctrl.sv
// Bench for rename_history_ctrl: directed scenarios plus random traffic checked
// against a queue-based model of the history buffer.
module tb_rename_history_ctrl;
    localparam int DEPTH  = 16;
    localparam int AREG_W = 3;
    localparam int PREG_W = 5;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rename_history_ctrl_if #(.AREG_W(AREG_W), .PREG_W(PREG_W), .CNT_W(CNT_W)) bus ();

    rename_history_ctrl #(.DEPTH(DEPTH), .AREG_W(AREG_W), .PREG_W(PREG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int arch;
        int newp;
        int oldp;
    } ent_t;

    ent_t hist[$];
    int   m_walk, m_err;
    int   e_fv, e_fp, e_rv, e_ra, e_rp;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_walk = 0; m_err = 0;
        e_fv = 0; e_fp = 0; e_rv = 0; e_ra = 0; e_rp = 0;
    endtask

    task automatic drive(input int rv, input int arch, input int np, input int op,
                         input int cv, input int fl);
        bus.ren_valid    = rv[0];
        bus.ren_arch     = arch[AREG_W-1:0];
        bus.ren_new_preg = np[PREG_W-1:0];
        bus.ren_old_preg = op[PREG_W-1:0];
        bus.commit_valid = cv[0];
        bus.flush        = fl[0];
    endtask

    task automatic check_outputs();
        check_eq("free_valid",  bus.free_valid,  e_fv);
        check_eq("free_preg",   bus.free_preg,   e_fp);
        check_eq("rat_wr_en",   bus.rat_wr_en,   e_rv);
        check_eq("rat_wr_arch", bus.rat_wr_arch, e_ra);
        check_eq("rat_wr_preg", bus.rat_wr_preg, e_rp);
        check_eq("busy",        bus.busy,        m_walk);
        check_eq("count",       bus.count,       hist.size());
        check_eq("err",         bus.err,         m_err);
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic step();
        int   ready_m;
        ent_t e;
        ready_m = (m_walk == 0 && hist.size() < DEPTH) ? 1 : 0;
        check_eq("ren_ready", bus.ren_ready, ready_m);
        @(posedge clk);
        e_fv = 0; e_fp = 0; e_rv = 0; e_ra = 0; e_rp = 0;
        if (m_walk != 0) begin
            e = hist.pop_back();
            e_rv = 1; e_ra = e.arch; e_rp = e.oldp;
            e_fv = 1; e_fp = e.newp;
            if (hist.size() == 0) m_walk = 0;
        end else begin
            if (bus.commit_valid) begin
                if (hist.size() > 0) begin
                    e = hist.pop_front();
                    e_fv = 1; e_fp = e.oldp;
                end else begin
                    m_err = 1;
                end
            end
            if (bus.flush) begin
                if (hist.size() > 0) m_walk = 1;
            end else if (bus.ren_valid && ready_m != 0) begin
                e.arch = int'(bus.ren_arch);
                e.newp = int'(bus.ren_new_preg);
                e.oldp = int'(bus.ren_old_preg);
                hist.push_back(e);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ra_tab[3];
        int rp_tab[3];
        int fp_tab[3];
        ra_tab = '{1, 2, 1};
        rp_tab = '{8, 2, 1};
        fp_tab = '{10, 9, 8};

        // Reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_outputs();
        check_eq("rst_ready", bus.ren_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Fill to DEPTH, then a 17th request must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, i % 8, 8 + i, i, 0, 0);
            step();
        end
        check_eq("full_count", bus.count, 16);
        check_eq("full_ready", bus.ren_ready, 0);
        drive(1, 7, 30, 31, 0, 0);
        step();
        check_eq("full_hold", bus.count, 16);

        // Commit with push at full: only commit happens
        drive(1, 7, 30, 31, 1, 0);
        step();
        check_eq("full_commit_fv", bus.free_valid, 1);
        check_eq("full_commit_fp", bus.free_preg, 0);
        check_eq("full_commit_cnt", bus.count, 15);
        idle();
        check_eq("ready_after_commit", bus.ren_ready, 1);

        // Drain the 15 remaining entries with a flush walk
        drive(0, 0, 0, 0, 0, 1);
        step();
        drive(1, 3, 3, 3, 1, 1);
        for (int i = 0; i < 40 && bus.busy; i++) step();
        check_eq("drain_done", bus.busy, 0);
        check_eq("drain_count", bus.count, 0);

        // Three-entry flush walk
        drive(1, 1, 8, 1, 0, 0);  step();
        drive(1, 2, 9, 2, 0, 0);  step();
        drive(1, 1, 10, 8, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1);  step();
        check_eq("walk_busy0", bus.busy, 1);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("walk_rat_arch", bus.rat_wr_arch, ra_tab[k]);
            check_eq("walk_rat_preg", bus.rat_wr_preg, rp_tab[k]);
            check_eq("walk_free_preg", bus.free_preg, fp_tab[k]);
        end
        check_eq("walk_end_busy", bus.busy, 0);
        idle();
        check_eq("walk_end_ready", bus.ren_ready, 1);

        // Flush + commit + push in the same cycle with two entries
        drive(1, 3, 20, 4, 0, 0); step();
        drive(1, 5, 21, 6, 0, 0); step();
        drive(1, 6, 22, 7, 1, 1); step();
        check_eq("fc_free_preg", bus.free_preg, 4);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_eq("fc_rat_arch", bus.rat_wr_arch, 5);
        check_eq("fc_rat_preg", bus.rat_wr_preg, 6);
        check_eq("fc_free_new", bus.free_preg, 21);
        check_eq("fc_count", bus.count, 0);
        idle();

        // Push/commit pairs across two pointer wraps
        drive(1, 0, 1, 2, 0, 0); step();
        for (int i = 0; i < 40; i++) begin
            drive(1, i % 8, (i + 3) % 32, (i + 5) % 32, 1, 0);
            step();
            check_eq("pair_count", bus.count, 1);
        end
        drive(0, 0, 0, 0, 1, 0); step();
        idle();

        // Reset in the middle of a walk
        for (int i = 0; i < 5; i++) begin
            drive(1, i, 10 + i, 20 + i, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0); step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check_eq("rst_walk_ready", bus.ren_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // Commit on empty sets sticky err
        drive(0, 0, 0, 0, 1, 0); step();
        check_eq("err_set", bus.err, 1);
        idle(); idle();
        check_eq("err_sticky", bus.err, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0 ? 1 : 0, $urandom % 8, $urandom % 32, $urandom % 32,
                  ($urandom % 3) == 0 ? 1 : 0, ($urandom % 40) == 0 ? 1 : 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
